parking_gate_ctrl: RTL and testbench
====================================

Name: parking_gate_ctrl

Overview:
- Entry-gate controller for the parking lot. It sits directly upstream of the open-door blinker and drives its door_open input.
- Detects a car at the entry, admits it only when a space is free, and sequences the gate motor through open, hold and close.
- Tracks occupancy from entry-pass and exit events.
- Timing is counted in ticks from an external time-base enable, typically the clock-divider output resynchronised into CLK as a 1-cycle pulse.

Parameters:
- CAPACITY, 8, number of parking spaces; 1..(2^CNT_W - 1).
- CNT_W, 4, width of the occupancy counter.
- MOVE_TICKS, 3, ticks the motor runs to fully raise or lower the gate; >= 1.
- OPEN_TICKS, 10, ticks the gate stays open waiting for the car to pass; >= 1.

Ports:
- CLK, in, 1, system clock; all logic on posedge.
- RST_N, in, 1, asynchronous active-low reset.
- tick, in, 1, single-cycle time-base enable, synchronous to CLK.
- entry_req, in, 1, level; car present at the entry sensor.
- car_passed, in, 1, single-cycle pulse; car crossed the gate line.
- exit_pulse, in, 1, single-cycle pulse; a car left via the exit.
- door_open, out, 1, single-cycle pulse on each gate-open start; feeds the blinker.
- motor_up, out, 1, raise motor drive.
- motor_down, out, 1, lower motor drive.
- gate_is_open, out, 1, gate fully raised.
- denied, out, 1, single-cycle pulse; an entry request was refused because the lot is full.
- full, out, 1, high when occupancy == CAPACITY.
- occupancy, out, CNT_W, cars currently inside.

Behaviour:
- Reset (RST_N=0, any time, including mid-motion):
  - State goes to IDLE.
  - All outputs, the occupancy counter, the tick counter and the entry edge register go to 0.
- Entry edge: a registered copy of entry_req is kept; entry_rise = entry_req & ~entry_req_q. A held level never retriggers.
- Outputs:
  - door_open, denied, motor_up, motor_down and gate_is_open are registered.
  - full is combinational from the occupancy register.
- State machine (encoding free: IDLE, OPENING, OPEN, CLOSING):
  - IDLE, entry_rise with !full: go to OPENING. door_open=1 for exactly the first cycle in OPENING. Tick counter cleared.
  - IDLE, entry_rise with full: stay in IDLE; denied=1 for 1 cycle.
  - OPENING: motor_up=1. When tick arrives with tcnt==MOVE_TICKS-1, go to OPEN. Exactly MOVE_TICKS ticks are consumed.
  - OPEN: gate_is_open=1.
    - car_passed: occupancy+1, go to CLOSING.
    - OPEN_TICKS ticks elapse with no pass: go to CLOSING with no increment.
    - car_passed and the final tick in the same cycle: the pass wins (increment).
  - CLOSING: motor_down=1. After MOVE_TICKS ticks, go to IDLE.
  - CLOSING, entry_rise with !full: reverse to OPENING, door_open pulse again, tick counter cleared.
  - CLOSING, entry_rise with full: denied pulse, keep closing.
  - car_passed outside OPEN is ignored.
  - entry_rise in OPENING or OPEN is ignored.
- Tick counter:
  - Cleared on every state change.
  - Increments only on tick.
  - Width is ceil(log2(max(MOVE_TICKS, OPEN_TICKS)+1)).
- Occupancy:
  - exit_pulse decrements in any state; saturates at 0, so an exit at 0 is ignored.
  - Increment is suppressed at CAPACITY and saturates. This is defensive only and cannot occur via the FSM.
  - car_passed and exit_pulse in the same cycle (with both valid) leave occupancy unchanged.
  - full tracks occupancy the cycle after any change.
- Mutual exclusion: motor_up and motor_down are never both 1. gate_is_open is never 1 while either motor is 1.

Test Plan:
- Reset mid-OPENING: assert RST_N=0 -> motor_up=0, occupancy=0, state IDLE immediately (asynchronously); after release, no spurious door_open.
- Normal entry (MOVE_TICKS=3, OPEN_TICKS=10): entry_req rise -> door_open 1-cycle pulse; motor_up for 3 ticks; gate_is_open; car_passed after 4 ticks -> occupancy 0->1; motor_down for 3 ticks; IDLE.
- Timeout: open with no car_passed -> CLOSING after exactly 10 ticks; occupancy unchanged; entry_req held high throughout -> no second door_open.
- Full lot (CAPACITY=2): admit 2 cars -> full=1; third entry_rise -> denied pulse, no door_open, no motor; one exit_pulse -> full=0; next entry_rise opens the gate.
- Reopen during close: entry_rise at CLOSING tick 1 -> immediate OPENING, new door_open pulse, motor_down=0 and motor_up=1 in the same cycle, full MOVE_TICKS re-count.
- Simultaneous events: car_passed with exit_pulse at occupancy 1 -> stays 1. exit_pulse at occupancy 0 -> stays 0. car_passed on the final OPEN tick -> counted.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Entry-gate controller: detects a car at the entry, admits it when a space
// is free, sequences the gate motor (open, hold, close) and tracks occupancy.
// Timing is counted in ticks of an external single-cycle time-base enable.
module parking_gate_ctrl #(
    parameter int CAPACITY   = 8,
    parameter int CNT_W      = 4,
    parameter int MOVE_TICKS = 3,
    parameter int OPEN_TICKS = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             tick,
    input  logic             entry_req,
    input  logic             car_passed,
    input  logic             exit_pulse,
    output logic             door_open,
    output logic             motor_up,
    output logic             motor_down,
    output logic             gate_is_open,
    output logic             denied,
    output logic             full,
    output logic [CNT_W-1:0] occupancy
);

    localparam int MAX_TICKS = (MOVE_TICKS > OPEN_TICKS) ? MOVE_TICKS : OPEN_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    localparam logic [TW-1:0]    MOVE_LAST = TW'(MOVE_TICKS - 1);
    localparam logic [TW-1:0]    OPEN_LAST = TW'(OPEN_TICKS - 1);
    localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE,
        OPENING,
        OPEN,
        CLOSING
    } state_t;

    state_t        state, state_nxt;
    logic          entry_req_q;
    logic          entry_rise;
    logic [TW-1:0] tcnt;
    logic          door_open_nxt;
    logic          denied_nxt;
    logic          pass_ev;
    logic          occ_inc;
    logic          occ_dec;

    assign entry_rise = entry_req & ~entry_req_q;
    assign full       = (occupancy == CAP_VAL);
    assign occ_inc    = pass_ev && (occupancy != CAP_VAL);
    assign occ_dec    = exit_pulse && (occupancy != '0);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and pulse decode
    always_comb begin
        state_nxt     = state;
        door_open_nxt = 1'b0;
        denied_nxt    = 1'b0;
        pass_ev       = 1'b0;
        case (state)
            IDLE: begin
                if (entry_rise) begin
                    if (full) begin
                        denied_nxt = 1'b1;
                    end else begin
                        state_nxt     = OPENING;
                        door_open_nxt = 1'b1;
                    end
                end
            end
            OPENING: begin
                if (tick && (tcnt == MOVE_LAST)) begin
                    state_nxt = OPEN;
                end
            end
            OPEN: begin
                // A pass on the final hold tick still counts as a pass
                if (car_passed) begin
                    state_nxt = CLOSING;
                    pass_ev   = 1'b1;
                end else if (tick && (tcnt == OPEN_LAST)) begin
                    state_nxt = CLOSING;
                end
            end
            CLOSING: begin
                if (entry_rise && !full) begin
                    state_nxt     = OPENING;
                    door_open_nxt = 1'b1;
                end else begin
                    if (entry_rise) begin
                        denied_nxt = 1'b1;
                    end
                    if (tick && (tcnt == MOVE_LAST)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tick counter: restarts on every state change, advances on tick
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tcnt <= '0;
        end else if (state_nxt != state) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Entry edge register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            entry_req_q <= 1'b0;
        end else begin
            entry_req_q <= entry_req;
        end
    end

    // Occupancy: saturating up/down, simultaneous pass and exit cancel
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            occupancy <= '0;
        end else if (occ_inc && !occ_dec) begin
            occupancy <= occupancy + 1'b1;
        end else if (occ_dec && !occ_inc) begin
            occupancy <= occupancy - 1'b1;
        end
    end

    // Registered outputs, derived from the state being entered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            door_open    <= 1'b0;
            denied       <= 1'b0;
            motor_up     <= 1'b0;
            motor_down   <= 1'b0;
            gate_is_open <= 1'b0;
        end else begin
            door_open    <= door_open_nxt;
            denied       <= denied_nxt;
            motor_up     <= (state_nxt == OPENING);
            motor_down   <= (state_nxt == CLOSING);
            gate_is_open <= (state_nxt == OPEN);
        end
    end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Testbench for parking_gate_ctrl: directed scenarios followed by random
// stimulus, all checked every cycle against a behavioural gate model.
module tb_parking_gate_ctrl;

    localparam int CAPACITY   = 2;
    localparam int CNT_W      = 4;
    localparam int MOVE_TICKS = 3;
    localparam int OPEN_TICKS = 10;

    logic             CLK;
    logic             RST_N;
    logic             tick;
    logic             entry_req;
    logic             car_passed;
    logic             exit_pulse;
    logic             door_open;
    logic             motor_up;
    logic             motor_down;
    logic             gate_is_open;
    logic             denied;
    logic             full;
    logic [CNT_W-1:0] occupancy;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: gate position and ticks remaining in the current move/hold
    typedef enum int {G_DOWN, G_RAISING, G_UP, G_LOWERING} gate_t;
    gate_t m_gate;
    int    m_left;
    int    m_occ;
    bit    m_prev_req;
    bit    m_door;
    bit    m_den;

    parking_gate_ctrl #(
        .CAPACITY  (CAPACITY),
        .CNT_W     (CNT_W),
        .MOVE_TICKS(MOVE_TICKS),
        .OPEN_TICKS(OPEN_TICKS)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .tick        (tick),
        .entry_req   (entry_req),
        .car_passed  (car_passed),
        .exit_pulse  (exit_pulse),
        .door_open   (door_open),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .gate_is_open(gate_is_open),
        .denied      (denied),
        .full        (full),
        .occupancy   (occupancy)
    );

    // 10 ns clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gate     = G_DOWN;
        m_left     = 0;
        m_occ      = 0;
        m_prev_req = 1'b0;
        m_door     = 1'b0;
        m_den      = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit r, input bit p, input bit e);
        bit rise;
        bit lot_full;
        int delta;
        rise       = r && !m_prev_req;
        m_prev_req = r;
        lot_full   = (m_occ == CAPACITY);
        m_door     = 1'b0;
        m_den      = 1'b0;
        delta      = 0;
        case (m_gate)
            G_DOWN: begin
                if (rise && lot_full) m_den = 1'b1;
                else if (rise) begin
                    m_gate = G_RAISING; m_left = MOVE_TICKS; m_door = 1'b1;
                end
            end
            G_RAISING: begin
                if (t) begin
                    m_left--;
                    if (m_left == 0) begin m_gate = G_UP; m_left = OPEN_TICKS; end
                end
            end
            G_UP: begin
                if (p) begin
                    if (m_occ < CAPACITY) delta = 1;
                    m_gate = G_LOWERING; m_left = MOVE_TICKS;
                end else if (t) begin
                    m_left--;
                    if (m_left == 0) begin m_gate = G_LOWERING; m_left = MOVE_TICKS; end
                end
            end
            G_LOWERING: begin
                if (rise && !lot_full) begin
                    m_gate = G_RAISING; m_left = MOVE_TICKS; m_door = 1'b1;
                end else begin
                    if (rise) m_den = 1'b1;
                    if (t) begin
                        m_left--;
                        if (m_left == 0) m_gate = G_DOWN;
                    end
                end
            end
            default: m_gate = G_DOWN;
        endcase
        if (e && m_occ > 0) delta = delta - 1;
        m_occ = m_occ + delta;
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "door_open"},    32'(door_open),    32'(m_door));
        check({pfx, "denied"},       32'(denied),       32'(m_den));
        check({pfx, "motor_up"},     32'(motor_up),     32'(m_gate == G_RAISING));
        check({pfx, "motor_down"},   32'(motor_down),   32'(m_gate == G_LOWERING));
        check({pfx, "gate_is_open"}, 32'(gate_is_open), 32'(m_gate == G_UP));
        check({pfx, "occupancy"},    32'(occupancy),    32'(m_occ));
        check({pfx, "full"},         32'(full),         32'(m_occ == CAPACITY));
        check({pfx, "mutex"},
              32'((motor_up & motor_down) | (gate_is_open & (motor_up | motor_down))), 32'd0);
    endtask

    // One clock: apply inputs, advance the model, sample 1 ns after the edge
    task automatic cyc(input bit t, input bit r, input bit p, input bit e);
        tick       = t;
        entry_req  = r;
        car_passed = p;
        exit_pulse = e;
        model_step(t, r, p, e);
        @(posedge CLK);
        #1;
        check_outputs("");
    endtask

    task automatic ticks(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, r, 1'b0, 1'b0);
            cyc(1'b1, r, 1'b0, 1'b0);
        end
    endtask

    initial begin
        RST_N      = 1'b0;
        tick       = 1'b0;
        entry_req  = 1'b0;
        car_passed = 1'b0;
        exit_pulse = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_outputs("rst_");
        @(negedge CLK);
        RST_N = 1'b1;

        // Normal entry with entry_req held; pass after 4 open ticks
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        ticks(4, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout with entry_req held throughout
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        ticks(OPEN_TICKS, 1'b1);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Fill the lot, get denied, free a space, re-admit
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        // Pass and exit together at occupancy 1
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        // Reopen on closing tick 1
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        // Pass on the final open tick
        ticks(OPEN_TICKS - 1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        // Full while closing: denied, keeps closing
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        // Exit at zero occupancy
        cyc(1'b0, 1'b0, 1'b0, 1'b1);

        // Admit one car, then reset in the middle of opening
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        ticks(MOVE_TICKS, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        RST_N     = 1'b0;
        entry_req = 1'b0;
        tick      = 1'b0;
        model_reset();
        #1;
        check_outputs("async_rst_");
        @(negedge CLK);
        RST_N = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit rt, rr, rp, re;
            rt = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 7) == 0) ? !entry_req : entry_req;
            rp = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 19) == 0);
            cyc(rt, rr, rp, re);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
